// File: rtl/usb_cdc_pkg.sv
// Shared definitions for the USB CDC TX arbiter: state encoding, byte width
// and the index-width helper used for owner / timeout_id fields.
package usb_cdc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int CDC_BYTE_W = 8;

  // Index width that never collapses to zero bits, so a 2-requester build
  // still gets a legal 1-bit id field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_cdc_rr_picker.sv
// Rotate-priority picker: returns the first asserted request found when
// searching upward from last_i+1, wrapping modulo NREQ. Purely combinational;
// any strict-priority override is layered on by the caller.
module usb_cdc_rr_picker
  import usb_cdc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o
);

  // Walk the NREQ candidates in rotated order and latch onto the first hit.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_cdc_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing the CDC TX FIFO write port between
// NREQ byte-stream requesters. A grant is held until the owner's last beat or
// until the stall watchdog fires after TIMEOUT starved cycles.
// Optional build macro USB_CDC_TX_ARB_PRIO_EN: requester 0 wins every packet
// boundary at which it is valid; the rest stay round-robin among themselves.
module usb_cdc_tx_arbiter
  import usb_cdc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256,
  parameter int TW      = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [CDC_BYTE_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         tx_fifo_full,
  output logic                         tx_fifo_wr,
  output logic [CDC_BYTE_W-1:0]        tx_fifo_wdata,
  output logic [NREQ-1:0]              grant,
  output logic                         busy,
  output logic                         timeout_pulse,
  output logic [clog2_min1(NREQ)-1:0]  timeout_id
);

  localparam int IW = clog2_min1(NREQ);

  arb_state_e            state_q;
  logic [NREQ-1:0]       grant_q;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         last_owner_q;
  logic [IW-1:0]         timeout_id_q;
  logic [TW-1:0]         stall_q;
  logic                  timeout_pulse_q;

  // Per-requester byte lanes, so the owner's byte is a plain array lookup.
  logic [CDC_BYTE_W-1:0] lane_data [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*CDC_BYTE_W +: CDC_BYTE_W];
    end
  endgenerate

  // Arbitration choice for the next packet boundary.
  logic [NREQ-1:0] rr_req;
  logic [NREQ-1:0] rr_onehot;
  logic [IW-1:0]   rr_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;

`ifdef USB_CDC_TX_ARB_PRIO_EN
  // Requester 0 bypasses the rotation; the picker only arbitrates the others.
  assign rr_req      = req_valid & ~NREQ'(1);
  assign pick_onehot = req_valid[0] ? NREQ'(1) : rr_onehot;
  assign pick_idx    = req_valid[0] ? '0 : rr_idx;
`else
  assign rr_req      = req_valid;
  assign pick_onehot = rr_onehot;
  assign pick_idx    = rr_idx;
`endif

  usb_cdc_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i    (rr_req),
    .last_i   (last_owner_q),
    .onehot_o (rr_onehot),
    .idx_o    (rr_idx)
  );

  // Datapath qualifiers for the current owner. rst_n is folded in so that a
  // reset cycle landing mid-packet never issues a FIFO write.
  logic in_grant;
  logic can_move;
  logic owner_valid;
  logic owner_last;
  logic accept;
  logic starve;
  logic stall_hit;

  assign in_grant    = (state_q == GRANT);
  assign can_move    = in_grant & rst_n & en & ~tx_fifo_full;
  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign accept      = can_move & owner_valid;
  // Backpressure and en=0 both clear can_move, so they freeze the watchdog.
  assign starve      = can_move & ~owner_valid;
  assign stall_hit   = (stall_q == TW'(TIMEOUT - 1));

  assign req_ready     = {NREQ{can_move}} & grant_q;
  assign tx_fifo_wr    = accept;
  assign tx_fifo_wdata = in_grant ? lane_data[owner_q] : '0;
  assign grant         = grant_q;
  assign busy          = in_grant;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_id    = timeout_id_q;

  // Arbiter FSM: grant at a boundary, hold for the packet, release on last or watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      owner_q         <= '0;
      last_owner_q    <= IW'(NREQ - 1);
      stall_q         <= '0;
      timeout_pulse_q <= 1'b0;
      timeout_id_q    <= '0;
    end else begin
      timeout_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && (|req_valid)) begin
            state_q <= GRANT;
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            stall_q <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            // An accepted beat always beats a simultaneous watchdog expiry.
            stall_q <= '0;
            if (owner_last) begin
              state_q      <= IDLE;
              grant_q      <= '0;
              last_owner_q <= owner_q;
            end
          end else if (starve) begin
            if (stall_hit) begin
              state_q         <= IDLE;
              grant_q         <= '0;
              last_owner_q    <= owner_q;
              stall_q         <= '0;
              timeout_pulse_q <= 1'b1;
              timeout_id_q    <= owner_q;
            end else begin
              stall_q <= stall_q + TW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
